// File: rtl/csr_register_file_if.sv
// CSR register file bus: decode-side read port, write-back commit port,
// retire tick and trap capture inputs, plus the combinational read results.
interface csr_register_file_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 12;

  logic            csr_read_enable;
  logic [AW-1:0]   csr_index;
  logic [XLEN-1:0] csr_read_data;
  logic            csr_write_enable;
  logic [AW-1:0]   csr_write_index;
  logic [XLEN-1:0] csr_write_data;
  logic            instret_tick;
  logic            trap_enable;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] trap_cause;
  logic            illegal_access;

  modport master (
    output csr_read_enable, csr_index, csr_write_enable, csr_write_index,
           csr_write_data, instret_tick, trap_enable, trap_pc, trap_cause,
    input  csr_read_data, illegal_access
  );

  modport slave (
    input  csr_read_enable, csr_index, csr_write_enable, csr_write_index,
           csr_write_data, instret_tick, trap_enable, trap_pc, trap_cause,
    output csr_read_data, illegal_access
  );
endinterface

// File: rtl/csr_register_file.sv
// Machine-mode CSR storage: combinational read, one committed write per clock,
// free-running mcycle/minstret counters and trap capture of mepc/mcause/mstatus.
// Optional feature macro: CSR_COUNTER_64_EN (64-bit counters with high-half CSRs).
module csr_register_file #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  csr_register_file_if.slave   bus
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 12;
`ifdef CSR_COUNTER_64_EN
  localparam int unsigned CNT_W = 64;
`else
  localparam int unsigned CNT_W = 32;
`endif

  localparam logic [AW-1:0] A_MSTATUS  = 12'h300;
  localparam logic [AW-1:0] A_MISA     = 12'h301;
  localparam logic [AW-1:0] A_MTVEC    = 12'h305;
  localparam logic [AW-1:0] A_MSCRATCH = 12'h340;
  localparam logic [AW-1:0] A_MEPC     = 12'h341;
  localparam logic [AW-1:0] A_MCAUSE   = 12'h342;
  localparam logic [AW-1:0] A_MCYCLE   = 12'hB00;
  localparam logic [AW-1:0] A_MINSTRET = 12'hB02;
  localparam logic [AW-1:0] A_CYCLE    = 12'hC00;
  localparam logic [AW-1:0] A_INSTRET  = 12'hC02;
  localparam logic [AW-1:0] A_MHARTID  = 12'hF14;
`ifdef CSR_COUNTER_64_EN
  localparam logic [AW-1:0] A_MCYCLEH   = 12'hB80;
  localparam logic [AW-1:0] A_MINSTRETH = 12'hB82;
  localparam logic [AW-1:0] A_CYCLEH    = 12'hC80;
  localparam logic [AW-1:0] A_INSTRETH  = 12'hC82;
`endif

  // MIE (3), MPIE (7) and MPP (12:11) are the only implemented mstatus bits
  localparam logic [XLEN-1:0] MSTATUS_MASK = 32'h0000_1888;
  localparam logic [XLEN-1:0] MTVEC_MASK   = ~32'h0000_0002;
  localparam logic [XLEN-1:0] MEPC_MASK    = ~32'h0000_0003;

  logic [XLEN-1:0]  mstatus_q;
  logic [XLEN-1:0]  mtvec_q;
  logic [XLEN-1:0]  mscratch_q;
  logic [XLEN-1:0]  mepc_q;
  logic [XLEN-1:0]  mcause_q;
  logic [CNT_W-1:0] mcycle_q;
  logic [CNT_W-1:0] minstret_q;
  logic [CNT_W-1:0] mcycle_d;
  logic [CNT_W-1:0] minstret_d;

  logic [XLEN-1:0]  rd_data_c;
  logic             rd_mapped_c;
  logic             wr_writable_c;
  logic             wr_commit_c;

  // Read mux; unmapped indices return zero and flag the miss
  always_comb begin
    rd_data_c   = '0;
    rd_mapped_c = 1'b1;
    case (bus.csr_index)
      A_MSTATUS:             rd_data_c = mstatus_q & MSTATUS_MASK;
      A_MISA:                rd_data_c = MISA_VALUE;
      A_MTVEC:               rd_data_c = mtvec_q;
      A_MSCRATCH:            rd_data_c = mscratch_q;
      A_MEPC:                rd_data_c = mepc_q;
      A_MCAUSE:              rd_data_c = mcause_q;
      A_MCYCLE, A_CYCLE:     rd_data_c = mcycle_q[XLEN-1:0];
      A_MINSTRET, A_INSTRET: rd_data_c = minstret_q[XLEN-1:0];
      A_MHARTID:             rd_data_c = HART_ID;
`ifdef CSR_COUNTER_64_EN
      A_MCYCLEH, A_CYCLEH:     rd_data_c = mcycle_q[CNT_W-1:XLEN];
      A_MINSTRETH, A_INSTRETH: rd_data_c = minstret_q[CNT_W-1:XLEN];
`endif
      default:               rd_mapped_c = 1'b0;
    endcase
  end

  // Write target must be a mapped read-write CSR; everything else is dropped
  always_comb begin
    wr_writable_c = 1'b0;
    case (bus.csr_write_index)
      A_MSTATUS, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
      A_MCYCLE, A_MINSTRET:  wr_writable_c = 1'b1;
`ifdef CSR_COUNTER_64_EN
      A_MCYCLEH, A_MINSTRETH: wr_writable_c = 1'b1;
`endif
      default:               wr_writable_c = 1'b0;
    endcase
  end

  assign wr_commit_c        = bus.csr_write_enable & wr_writable_c;
  assign bus.csr_read_data  = rd_data_c;
  assign bus.illegal_access = (bus.csr_read_enable & ~rd_mapped_c) |
                              (bus.csr_write_enable & ~wr_writable_c);

  // Counter next values: a software write to either half replaces the increment
  always_comb begin
    mcycle_d   = mcycle_q + CNT_W'(1);
    minstret_d = bus.instret_tick ? (minstret_q + CNT_W'(1)) : minstret_q;
    if (wr_commit_c) begin
      case (bus.csr_write_index)
        A_MCYCLE: begin
          mcycle_d             = mcycle_q;
          mcycle_d[XLEN-1:0]   = bus.csr_write_data;
        end
        A_MINSTRET: begin
          minstret_d           = minstret_q;
          minstret_d[XLEN-1:0] = bus.csr_write_data;
        end
`ifdef CSR_COUNTER_64_EN
        A_MCYCLEH: begin
          mcycle_d                 = mcycle_q;
          mcycle_d[CNT_W-1:XLEN]   = bus.csr_write_data;
        end
        A_MINSTRETH: begin
          minstret_d               = minstret_q;
          minstret_d[CNT_W-1:XLEN] = bus.csr_write_data;
        end
`endif
        default: ;
      endcase
    end
  end

  // CSR state; trap capture takes priority over software writes to trap CSRs
  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_q  <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
      if (wr_commit_c) begin
        case (bus.csr_write_index)
          A_MTVEC:    mtvec_q    <= bus.csr_write_data & MTVEC_MASK;
          A_MSCRATCH: mscratch_q <= bus.csr_write_data;
          A_MSTATUS:  if (!bus.trap_enable) mstatus_q <= bus.csr_write_data & MSTATUS_MASK;
          A_MEPC:     if (!bus.trap_enable) mepc_q    <= bus.csr_write_data & MEPC_MASK;
          A_MCAUSE:   if (!bus.trap_enable) mcause_q  <= bus.csr_write_data;
          default: ;
        endcase
      end
      if (bus.trap_enable) begin
        mepc_q    <= bus.trap_pc & MEPC_MASK;
        mcause_q  <= bus.trap_cause;
        mstatus_q <= {mstatus_q[31:8], mstatus_q[3], mstatus_q[6:4], 1'b0, mstatus_q[2:0]};
      end
    end
  end

endmodule

// File: tb/tb_csr_register_file.sv
// Self-checking bench for csr_register_file: directed scenarios plus a randomized
// run, all compared against an architectural model of the CSR file.
module tb_csr_register_file;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  csr_register_file_if bus ();

  csr_register_file dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

`ifdef CSR_COUNTER_64_EN
  localparam logic [63:0] CMASK = 64'hFFFF_FFFF_FFFF_FFFF;
`else
  localparam logic [63:0] CMASK = 64'h0000_0000_FFFF_FFFF;
`endif

  // Architectural model state
  logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_mcycle, m_minstret;

  logic [11:0] idx_list [0:18] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341,
                                   12'h342, 12'hB00, 12'hB02, 12'hC00, 12'hC02,
                                   12'hF14, 12'hB80, 12'hB82, 12'hC80, 12'hC82,
                                   12'h7FF, 12'h000, 12'h343, 12'hFFF};

  function automatic logic [31:0] m_read(input logic [11:0] i);
    case (i)
      12'h300: return m_mstatus;
      12'h301: return 32'h4000_0100;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00, 12'hC00: return m_mcycle[31:0];
      12'hB02, 12'hC02: return m_minstret[31:0];
      12'hF14: return 32'h0;
`ifdef CSR_COUNTER_64_EN
      12'hB80, 12'hC80: return m_mcycle[63:32];
      12'hB82, 12'hC82: return m_minstret[63:32];
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_mapped(input logic [11:0] i);
    bit hi = (i == 12'hB80) || (i == 12'hB82) || (i == 12'hC80) || (i == 12'hC82);
`ifdef CSR_COUNTER_64_EN
    if (hi) return 1'b1;
`else
    if (hi) return 1'b0;
`endif
    return (i == 12'h300) || (i == 12'h301) || (i == 12'h305) || (i == 12'h340) ||
           (i == 12'h341) || (i == 12'h342) || (i == 12'hB00) || (i == 12'hB02) ||
           (i == 12'hC00) || (i == 12'hC02) || (i == 12'hF14);
  endfunction

  // Writable = mapped, not in the 0xC00-0xFFF read-only space, and not misa
  function automatic bit m_writable(input logic [11:0] i);
    return m_mapped(i) && (i[11:10] != 2'b11) && (i != 12'h301);
  endfunction

  // Advance the model by one clock using the inputs currently on the bus
  task automatic model_commit();
    bit wr;
    if (reset) begin
      m_mstatus = 0; m_mtvec = 32'h0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
      m_mcycle = 0; m_minstret = 0;
      return;
    end
    wr = bus.csr_write_enable && m_writable(bus.csr_write_index);
    if (wr && bus.csr_write_index == 12'hB00)      m_mcycle[31:0]  = bus.csr_write_data;
    else if (wr && bus.csr_write_index == 12'hB80) m_mcycle[63:32] = bus.csr_write_data;
    else m_mcycle = (m_mcycle + 64'd1) & CMASK;
    if (wr && bus.csr_write_index == 12'hB02)      m_minstret[31:0]  = bus.csr_write_data;
    else if (wr && bus.csr_write_index == 12'hB82) m_minstret[63:32] = bus.csr_write_data;
    else if (bus.instret_tick) m_minstret = (m_minstret + 64'd1) & CMASK;
    if (wr) begin
      if (bus.csr_write_index == 12'h305) m_mtvec = bus.csr_write_data & ~32'h2;
      if (bus.csr_write_index == 12'h340) m_mscratch = bus.csr_write_data;
      if (!bus.trap_enable) begin
        if (bus.csr_write_index == 12'h300) m_mstatus = bus.csr_write_data & 32'h0000_1888;
        if (bus.csr_write_index == 12'h341) m_mepc    = bus.csr_write_data & ~32'h3;
        if (bus.csr_write_index == 12'h342) m_mcause  = bus.csr_write_data;
      end
    end
    if (bus.trap_enable) begin
      m_mepc       = bus.trap_pc & ~32'h3;
      m_mcause     = bus.trap_cause;
      m_mstatus[7] = m_mstatus[3];
      m_mstatus[3] = 1'b0;
    end
  endtask

  task automatic step();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.csr_read_enable = 0; bus.csr_index = 0; bus.csr_write_enable = 0;
    bus.csr_write_index = 0; bus.csr_write_data = 0; bus.instret_tick = 0;
    bus.trap_enable = 0; bus.trap_pc = 0; bus.trap_cause = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    bus.csr_write_enable = 1; bus.csr_write_index = 12'h340; bus.csr_write_data = 32'h1234_5678;
    step();
    bus.csr_index = 12'h340; #1;
    vectors++;
    if (bus.csr_read_data !== 32'h0) begin
      errors++; $display("FAIL reset_during: mscratch got %h exp %h", bus.csr_read_data, 32'h0);
    end
    step(); step();
    reset = 0; idle_inputs();
    bus.csr_index = 12'h305; #1;
    vectors++;
    if (bus.csr_read_data !== 32'h0) begin
      errors++; $display("FAIL reset_mtvec: got %h exp %h", bus.csr_read_data, 32'h0);
    end
    bus.csr_index = 12'h341; #1;
    vectors++;
    if (bus.csr_read_data !== 32'h0) begin
      errors++; $display("FAIL reset_mepc: got %h exp %h", bus.csr_read_data, 32'h0);
    end
    bus.csr_index = 12'h340; #1;
    vectors++;
    if (bus.csr_read_data !== 32'h0) begin
      errors++; $display("FAIL reset_write_discard: got %h exp %h", bus.csr_read_data, 32'h0);
    end
    for (int c = 0; c < 4; c++) begin
      bus.csr_index = 12'hB00; #1;
      vectors++;
      if (bus.csr_read_data !== 32'(c)) begin
        errors++; $display("FAIL reset_mcycle_%0d: got %h exp %h", c, bus.csr_read_data, 32'(c));
      end
      step();
    end
  endtask

  task automatic test_mscratch();
    bus.csr_write_enable = 1; bus.csr_write_index = 12'h340; bus.csr_write_data = 32'hDEAD_BEEF;
    bus.csr_read_enable = 1; bus.csr_index = 12'h340; #1;
    vectors++;
    if (bus.csr_read_data !== 32'h0) begin
      errors++; $display("FAIL mscratch_same_cycle: got %h exp %h", bus.csr_read_data, 32'h0);
    end
    step();
    idle_inputs(); bus.csr_index = 12'h340; #1;
    vectors++;
    if (bus.csr_read_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL mscratch_next: got %h exp %h", bus.csr_read_data, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_illegal();
    logic [11:0] bad [0:1] = '{12'hC00, 12'h7FF};
    for (int k = 0; k < 2; k++) begin
      idle_inputs();
      bus.csr_write_enable = 1; bus.csr_write_index = bad[k]; bus.csr_write_data = 32'd5;
      bus.csr_index = 12'hC00; #1;
      vectors++;
      if (bus.illegal_access !== 1'b1) begin
        errors++; $display("FAIL illegal_wr_%h: got %b exp 1", bad[k], bus.illegal_access);
      end
      step();
      bus.csr_write_enable = 0; #1;
      vectors++;
      if (bus.csr_read_data !== m_read(12'hC00)) begin
        errors++; $display("FAIL illegal_cycle_%h: got %h exp %h", bad[k], bus.csr_read_data, m_read(12'hC00));
      end
      bus.csr_index = 12'h340; #1;
      vectors++;
      if (bus.csr_read_data !== 32'hDEAD_BEEF) begin
        errors++; $display("FAIL illegal_noupdate_%h: got %h exp %h", bad[k], bus.csr_read_data, 32'hDEAD_BEEF);
      end
    end
    idle_inputs(); bus.csr_read_enable = 1; bus.csr_index = 12'h7FF; #1;
    vectors++;
    if (bus.illegal_access !== 1'b1 || bus.csr_read_data !== 32'h0) begin
      errors++; $display("FAIL illegal_rd: got %b/%h exp 1/%h", bus.illegal_access, bus.csr_read_data, 32'h0);
    end
    bus.csr_index = 12'h301; #1;
    vectors++;
    if (bus.illegal_access !== 1'b0 || bus.csr_read_data !== 32'h4000_0100) begin
      errors++; $display("FAIL misa_rd: got %b/%h exp 0/%h", bus.illegal_access, bus.csr_read_data, 32'h4000_0100);
    end
    bus.csr_index = 12'hB80; #1;
    vectors++;
    if (bus.illegal_access !== !m_mapped(12'hB80)) begin
      errors++; $display("FAIL hi_half_rd: got %b exp %b", bus.illegal_access, !m_mapped(12'hB80));
    end
    idle_inputs();
  endtask

  task automatic test_trap();
    bus.csr_write_enable = 1; bus.csr_write_index = 12'h300; bus.csr_write_data = 32'hFFFF_FFF8;
    step();
    idle_inputs(); bus.csr_index = 12'h300; #1;
    vectors++;
    if (bus.csr_read_data !== 32'h0000_1888) begin
      errors++; $display("FAIL mstatus_mask: got %h exp %h", bus.csr_read_data, 32'h0000_1888);
    end
    bus.trap_enable = 1; bus.trap_pc = 32'h0000_1003; bus.trap_cause = 32'd2;
    bus.csr_write_enable = 1; bus.csr_write_index = 12'h341; bus.csr_write_data = 32'h40;
    step();
    idle_inputs(); bus.csr_index = 12'h341; #1;
    vectors++;
    if (bus.csr_read_data !== 32'h0000_1000) begin
      errors++; $display("FAIL trap_mepc: got %h exp %h", bus.csr_read_data, 32'h0000_1000);
    end
    bus.csr_index = 12'h342; #1;
    vectors++;
    if (bus.csr_read_data !== 32'd2) begin
      errors++; $display("FAIL trap_mcause: got %h exp %h", bus.csr_read_data, 32'd2);
    end
    bus.csr_index = 12'h300; #1;
    vectors++;
    if (bus.csr_read_data !== 32'h0000_1880) begin
      errors++; $display("FAIL trap_mstatus: got %h exp %h", bus.csr_read_data, 32'h0000_1880);
    end
    bus.trap_enable = 1; bus.trap_pc = $urandom; bus.trap_cause = $urandom;
    bus.csr_write_enable = 1; bus.csr_write_index = 12'h340; bus.csr_write_data = 32'h55;
    step();
    idle_inputs(); bus.csr_index = 12'h340; #1;
    vectors++;
    if (bus.csr_read_data !== 32'h55) begin
      errors++; $display("FAIL trap_other_write: got %h exp %h", bus.csr_read_data, 32'h55);
    end
    bus.csr_index = 12'h341; #1;
    vectors++;
    if (bus.csr_read_data !== m_read(12'h341)) begin
      errors++; $display("FAIL trap2_mepc: got %h exp %h", bus.csr_read_data, m_read(12'h341));
    end
  endtask

  task automatic test_counter_wrap();
    logic [31:0] exp_seq [0:2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
    bus.csr_write_enable = 1; bus.csr_write_index = 12'hB00; bus.csr_write_data = 32'hFFFF_FFFE;
    step();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      bus.csr_index = 12'hB00; #1;
      vectors++;
      if (bus.csr_read_data !== exp_seq[c]) begin
        errors++; $display("FAIL wrap_%0d: got %h exp %h", c, bus.csr_read_data, exp_seq[c]);
      end
      if (c < 2) step();
    end
`ifdef CSR_COUNTER_64_EN
    bus.csr_index = 12'hB80; #1;
    vectors++;
    if (bus.csr_read_data !== 32'd1) begin
      errors++; $display("FAIL wrap_high: got %h exp %h", bus.csr_read_data, 32'd1);
    end
`endif
  endtask

  task automatic test_instret();
    for (int c = 0; c < 4; c++) begin
      idle_inputs(); bus.instret_tick = 1;
      if (c == 1) begin
        bus.csr_write_enable = 1; bus.csr_write_index = 12'hB02; bus.csr_write_data = 32'd10;
      end
      step();
    end
    idle_inputs(); bus.csr_index = 12'hB02; #1;
    vectors++;
    if (bus.csr_read_data !== 32'd12) begin
      errors++; $display("FAIL instret_final: got %h exp %h", bus.csr_read_data, 32'd12);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] exp_d;
      logic        exp_ill;
      bus.csr_index        = ($urandom_range(0, 9) == 0) ? 12'($urandom) : idx_list[$urandom_range(0, 18)];
      bus.csr_read_enable  = 1'($urandom_range(0, 1));
      bus.csr_write_enable = ($urandom_range(0, 2) == 0);
      bus.csr_write_index  = idx_list[$urandom_range(0, 18)];
      bus.csr_write_data   = $urandom;
      bus.instret_tick     = 1'($urandom_range(0, 1));
      bus.trap_enable      = ($urandom_range(0, 11) == 0);
      bus.trap_pc          = $urandom;
      bus.trap_cause       = $urandom;
      reset                = ($urandom_range(0, 79) == 0);
      #1;
      exp_d   = m_read(bus.csr_index);
      exp_ill = (bus.csr_read_enable && !m_mapped(bus.csr_index)) ||
                (bus.csr_write_enable && !m_writable(bus.csr_write_index));
      vectors++;
      if (bus.csr_read_data !== exp_d) begin
        errors++; $display("FAIL rand_read[%0d] idx %h: got %h exp %h", n, bus.csr_index, bus.csr_read_data, exp_d);
      end
      vectors++;
      if (bus.illegal_access !== exp_ill) begin
        errors++; $display("FAIL rand_illegal[%0d]: got %b exp %b", n, bus.illegal_access, exp_ill);
      end
      step();
    end
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    m_mstatus = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    m_mcycle = 0; m_minstret = 0;
    @(posedge clk); #1;
    test_reset();
    test_mscratch();
    test_illegal();
    test_trap();
    test_counter_wrap();
    test_instret();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
